// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR on WIDTH-bit operands, up to STEP bits per cycle.
// The result register dout only changes on the edge that completes an operation.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W-1:0] k_wrap;
  logic [WIDTH-1:0]   shifted;

  // k is never zero in SHIFT, so WIDTH-k (taken mod WIDTH) is a valid rotate distance.
  always_comb begin
    k      = (cnt_q < STEP_K) ? cnt_q : STEP_K;
    k_wrap = SHAMT_W'(0) - k;
    case (op_q)
      OP_SLL:  shifted = acc_q << k;
      OP_SRL:  shifted = acc_q >> k;
      OP_SRA:  shifted = WIDTH'($signed(acc_q) >>> k);
      default: shifted = (acc_q >> k) | (acc_q << k_wrap);
    endcase
  end

  // Handshake: start is taken only when busy=0 (IDLE or DONE); while busy=1 it is
  // dropped, not queued. done is high for exactly the cycle dout first holds a result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    case (state_q)
      ST_SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - k;
        if (cnt_q == k) begin
          state_d = ST_DONE;
          dout_d  = shifted;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          acc_d = din;
          cnt_d = shamt;
          op_d  = op;
          if (shamt == '0) begin
            state_d = ST_DONE;
            dout_d  = din;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed and model-checked stimulus for seq_shift_unit at STEP = 1, 2, 4 and 8.
// Instance index d carries STEP = 1 << d.
module tb_seq_shift_unit;

  logic             clk;
  logic             rst_n;
  logic [3:0]       start;
  logic [3:0][1:0]  op;
  logic [3:0][31:0] din;
  logic [3:0][4:0]  shamt;
  logic [3:0]       busy;
  logic [3:0]       done;
  logic [3:0][31:0] dout;

  int tests_run;
  int tests_failed;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start[g]),
      .op    (op[g]),
      .din   (din[g]),
      .shamt (shamt[g]),
      .busy  (busy[g]),
      .done  (done[g]),
      .dout  (dout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request across a single rising edge, sampled on negedges.
  task automatic launch(input int d, input logic [1:0] o, input logic [31:0] x,
                        input logic [4:0] s);
    start[d] = 1'b1;
    op[d]    = o;
    din[d]   = x;
    shamt[d] = s;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // lat counts edges from the accepting edge (edge 1) to the one that raises done.
  task automatic wait_done(input int d, output int lat, output int bcy);
    lat = 1;
    bcy = 0;
    while (done[d] !== 1'b1) begin
      if (busy[d] === 1'b1) bcy++;
      if (lat >= 100) begin
        tests_run++;
        tests_failed++;
        $error("FAIL timeout: dut %0d observed no done expected done within 100 edges", d);
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] x,
                        input logic [4:0] s, output logic [31:0] res,
                        output int lat, output int bcy);
    launch(d, o, x, s);
    wait_done(d, lat, bcy);
    res = dout[d];
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x,
                                            input int s);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < s; i++) begin
      case (o)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [31:0] res;
    int          lat;
    int          bcy;
    int          pulses;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = '0;
    op           = '0;
    din          = '0;
    shamt        = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_busy_%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("reset_done_%0d", d), 32'(done[d]), 32'd0);
      check($sformatf("reset_dout_%0d", d), dout[d], 32'h0);
    end

    // STEP=1 directed vectors
    run_op(0, 2'b10, 32'h8000_0000, 5'd4, res, lat, bcy);
    check("sra4_dout", res, 32'hF800_0000);
    check("sra4_lat", 32'(lat), 32'd5);
    check("sra4_busy", 32'(bcy), 32'd4);
    @(negedge clk);
    check("sra4_done_single", 32'(done[0]), 32'd0);
    check("sra4_dout_held", dout[0], 32'hF800_0000);

    run_op(0, 2'b01, 32'h8000_0000, 5'd4, res, lat, bcy);
    check("srl4_dout", res, 32'h0800_0000);
    check("srl4_lat", 32'(lat), 32'd5);

    run_op(0, 2'b00, 32'h0000_0001, 5'd31, res, lat, bcy);
    check("sll31_dout", res, 32'h8000_0000);
    check("sll31_lat", 32'(lat), 32'd32);

    run_op(0, 2'b11, 32'h0000_000F, 5'd4, res, lat, bcy);
    check("ror4_dout", res, 32'hF000_0000);

    run_op(0, 2'b10, 32'h1234_5678, 5'd0, res, lat, bcy);
    check("sh0_dout", res, 32'h1234_5678);
    check("sh0_lat", 32'(lat), 32'd1);
    check("sh0_busy", 32'(bcy), 32'd0);

    // STEP=4: SRA by 7 takes k=4 then k=3
    run_op(2, 2'b10, 32'h8000_0000, 5'd7, res, lat, bcy);
    check("s4_sra7_dout", res, 32'hFF00_0000);
    check("s4_sra7_lat", 32'(lat), 32'd3);
    check("s4_sra7_busy", 32'(bcy), 32'd2);

    // Back-to-back: second start presented during the DONE cycle
    run_op(2, 2'b00, 32'h0000_0001, 5'd5, res, lat, bcy);
    check("b2b_first_dout", res, 32'h0000_0020);
    check("b2b_first_lat", 32'(lat), 32'd3);
    launch(2, 2'b01, 32'h0000_0100, 5'd8);
    check("b2b_done_drop", 32'(done[2]), 32'd0);
    check("b2b_busy", 32'(busy[2]), 32'd1);
    check("b2b_dout_hold", dout[2], 32'h0000_0020);
    wait_done(2, lat, bcy);
    check("b2b_second_dout", dout[2], 32'h0000_0001);
    check("b2b_second_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check("b2b_done_single", 32'(done[2]), 32'd0);

    // start pulsed during SHIFT is ignored and not queued
    launch(0, 2'b01, 32'hF000_0000, 5'd8);
    start[0] = 1'b1;
    op[0]    = 2'b00;
    din[0]   = 32'hFFFF_FFFF;
    shamt[0] = 5'd1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, lat, bcy);
    check("ign_dout", dout[0], 32'h00F0_0000);
    check("ign_lat", 32'(lat + 1), 32'd9);
    @(negedge clk);
    check("ign_no_queue_done", 32'(done[0]), 32'd0);
    check("ign_no_queue_busy", 32'(busy[0]), 32'd0);

    // Reset mid-SHIFT aborts with no done pulse
    launch(0, 2'b00, 32'h0000_0001, 5'd20);
    repeat (3) @(negedge clk);
    check("abort_pre_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_dout", dout[0], 32'h0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done[0] === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);

    // Model-checked ops at STEP = 1, 2, 8
    for (int j = 0; j < 3; j++) begin
      int          d;
      int          stp;
      logic [1:0]  o;
      logic [31:0] x;
      logic [4:0]  s;
      d   = (j == 2) ? 3 : j;
      stp = 1 << d;
      for (int n = 0; n < 350; n++) begin
        o = 2'($urandom_range(0, 3));
        x = $urandom();
        s = 5'($urandom_range(0, 31));
        run_op(d, o, x, s, res, lat, bcy);
        check($sformatf("rnd_s%0d_op%0d_sh%0d_dout", stp, o, s), res, ref_shift(o, x, int'(s)));
        check($sformatf("rnd_s%0d_op%0d_sh%0d_lat", stp, o, s), 32'(lat),
              32'((int'(s) + stp - 1) / stp + 1));
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
